// File: rtl/nw_aligner.sv
// Needleman-Wunsch aligner with runtime lengths and weights.
// Fills the DP matrix one cell per cycle with a single row buffer, then streams the traceback path.
module nw_aligner #(
  parameter int MAX_LEN     = 16,
  parameter int CWIDTH      = 2,
  parameter int SWIDTH      = 16,
  parameter int CORD_LENGTH = 8,
  parameter int WWIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CORD_LENGTH-1:0]        len1,
  input  logic [CORD_LENGTH-1:0]        len2,
  input  logic [MAX_LEN*CWIDTH-1:0]     s1,
  input  logic [MAX_LEN*CWIDTH-1:0]     s2,
  input  logic [WWIDTH-1:0]             w_match,
  input  logic [WWIDTH-1:0]             w_mismatch,
  input  logic [WWIDTH-1:0]             w_indel,
  output logic                          busy,
  output logic signed [SWIDTH-1:0]      score,
  output logic                          score_valid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CORD_LENGTH-1:0]        out_y,
  output logic [CORD_LENGTH-1:0]        out_x,
  output logic [1:0]                    out_dir,
  output logic                          out_last,
  output logic                          done,
  output logic                          err
);

  localparam int AW = $clog2(MAX_LEN + 1);
  localparam logic [1:0] DIR_TOP    = 2'b00;
  localparam logic [1:0] DIR_LEFT   = 2'b01;
  localparam logic [1:0] DIR_CORNER = 2'b10;

  typedef enum logic [2:0] {IDLE, FILL, TB_READ, TB_EMIT, DONE} state_t;

  state_t state, state_nxt;

  logic [CORD_LENGTH-1:0]    len1_r, len2_r, i, j, nxt_i, nxt_j, i_m1, j_m1;
  logic [MAX_LEN*CWIDTH-1:0] s1_r, s2_r;
  logic signed [SWIDTH-1:0]  w_match_r, w_mismatch_r, w_indel_r;
  logic signed [SWIDTH-1:0]  h_diag, h_left, h_edge;
  logic signed [SWIDTH-1:0]  row [0:MAX_LEN];
  logic [1:0]                dmem [0:MAX_LEN][0:MAX_LEN];

  logic [AW-1:0]             i_a, j_a;
  logic [CWIDTH-1:0]         c1, c2;
  logic signed [SWIDTH-1:0]  w_sub, cand_corner, cand_above, cand_left, best;
  logic [1:0]                best_dir, tb_dir;
  logic [CORD_LENGTH-1:0]    tb_ni, tb_nj;
  logic                      illegal_len, last_cell;

  assign i_a  = i[AW-1:0];
  assign j_a  = j[AW-1:0];
  assign i_m1 = i - CORD_LENGTH'(1);
  assign j_m1 = j - CORD_LENGTH'(1);

  assign illegal_len = (len1 == '0) || (len2 == '0) ||
                       (len1 > CORD_LENGTH'(MAX_LEN)) || (len2 > CORD_LENGTH'(MAX_LEN));
  assign last_cell   = (i == len1_r) && (j == len2_r);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == TB_EMIT);

  always_comb begin
    c1 = '0;
    c2 = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (i_m1 == CORD_LENGTH'(k)) c1 = s1_r[k*CWIDTH +: CWIDTH];
      if (j_m1 == CORD_LENGTH'(k)) c2 = s2_r[k*CWIDTH +: CWIDTH];
    end
  end

  // Ties resolve toward CORNER first, then TOP.
  always_comb begin
    w_sub       = (c1 == c2) ? w_match_r : w_mismatch_r;
    cand_corner = h_diag + w_sub;
    cand_above  = row[j_a] + w_indel_r;
    cand_left   = h_left + w_indel_r;
    best        = cand_left;
    best_dir    = DIR_LEFT;
    if ((cand_corner >= cand_above) && (cand_corner >= cand_left)) begin
      best     = cand_corner;
      best_dir = DIR_CORNER;
    end else if (cand_above >= cand_left) begin
      best     = cand_above;
      best_dir = DIR_TOP;
    end
  end

  always_comb begin
    tb_dir = dmem[i_a][j_a];
    if (i == '0)      tb_dir = DIR_LEFT;
    else if (j == '0) tb_dir = DIR_TOP;
    tb_ni = (tb_dir == DIR_LEFT) ? i : i_m1;
    tb_nj = (tb_dir == DIR_TOP)  ? j : j_m1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = illegal_len ? DONE : FILL;
      FILL:    if (last_cell) state_nxt = TB_READ;
      TB_READ: state_nxt = TB_EMIT;
      TB_EMIT: if (out_ready) state_nxt = out_last ? DONE : TB_READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len1_r <= '0; len2_r <= '0; s1_r <= '0; s2_r <= '0;
      w_match_r <= '0; w_mismatch_r <= '0; w_indel_r <= '0;
      i <= '0; j <= '0; nxt_i <= '0; nxt_j <= '0;
      h_diag <= '0; h_left <= '0; h_edge <= '0;
      score <= '0; score_valid <= 1'b0; err <= 1'b0;
      out_y <= '0; out_x <= '0; out_dir <= '0; out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          len1_r       <= len1;
          len2_r       <= len2;
          s1_r         <= s1;
          s2_r         <= s2;
          w_match_r    <= SWIDTH'($signed(w_match));
          w_mismatch_r <= SWIDTH'($signed(w_mismatch));
          w_indel_r    <= SWIDTH'($signed(w_indel));
          score_valid  <= 1'b0;
          err          <= illegal_len;
          if (illegal_len) begin
            score <= '0;
          end else begin
            i      <= CORD_LENGTH'(1);
            j      <= CORD_LENGTH'(1);
            h_diag <= '0;
            h_left <= SWIDTH'($signed(w_indel));
            h_edge <= SWIDTH'($signed(w_indel));
          end
        end
        // h_edge tracks H[i][0] so row starts need no multiplier.
        FILL: begin
          if (j == len2_r) begin
            if (i == len1_r) begin
              score       <= best;
              score_valid <= 1'b1;
            end else begin
              i      <= i + CORD_LENGTH'(1);
              j      <= CORD_LENGTH'(1);
              h_diag <= h_edge;
              h_left <= h_edge + w_indel_r;
              h_edge <= h_edge + w_indel_r;
            end
          end else begin
            j      <= j + CORD_LENGTH'(1);
            h_diag <= row[j_a];
            h_left <= best;
          end
        end
        TB_READ: begin
          out_y    <= i;
          out_x    <= j;
          out_dir  <= tb_dir;
          out_last <= (tb_ni == '0) && (tb_nj == '0);
          nxt_i    <= tb_ni;
          nxt_j    <= tb_nj;
        end
        TB_EMIT: if (out_ready) begin
          i <= nxt_i;
          j <= nxt_j;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int k = 0; k <= MAX_LEN; k++)
        row[k] <= $signed(SWIDTH'(k)) * SWIDTH'($signed(w_indel));
    end else if (state == FILL) begin
      row[j_a]       <= best;
      dmem[i_a][j_a] <= best_dir;
    end
  end

endmodule

// File: tb/tb_nw_aligner.sv
// Randomized self-checking bench for nw_aligner against a full-matrix reference model.
module tb_nw_aligner;
  localparam int MAX_LEN = 16, CWIDTH = 2, SWIDTH = 16, CORD_LENGTH = 8, WWIDTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [CORD_LENGTH-1:0] len1 = '0, len2 = '0;
  logic [MAX_LEN*CWIDTH-1:0] s1 = '0, s2 = '0;
  logic [WWIDTH-1:0] w_match = '0, w_mismatch = '0, w_indel = '0;
  logic busy, score_valid, out_valid, out_last, done, err;
  logic out_ready = 1'b0;
  logic signed [SWIDTH-1:0] score;
  logic [CORD_LENGTH-1:0] out_y, out_x;
  logic [1:0] out_dir;

  nw_aligner #(.MAX_LEN(MAX_LEN), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH),
               .CORD_LENGTH(CORD_LENGTH), .WWIDTH(WWIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .len1(len1), .len2(len2),
    .s1(s1), .s2(s2), .w_match(w_match), .w_mismatch(w_mismatch), .w_indel(w_indel),
    .busy(busy), .score(score), .score_valid(score_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_x(out_x), .out_dir(out_dir),
    .out_last(out_last), .done(done), .err(err));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int exp_score;
  int exp_y[$], exp_x[$], exp_d[$], exp_l[$];
  int obs_y[$], obs_x[$], obs_d[$], obs_l[$];
  int fill_cnt;
  int obs_score;
  bit stable_ok, timed_out;

  // Full-matrix DP and traceback, straight from the scoring rules.
  task automatic model(input int l1, input int l2, input logic [MAX_LEN*CWIDTH-1:0] a,
                       input logic [MAX_LEN*CWIDTH-1:0] b, input int wm, input int wmm, input int wi);
    int h [0:MAX_LEN][0:MAX_LEN];
    int d [0:MAX_LEN][0:MAX_LEN];
    int c, t, l, y, x, dir, ny, nx;
    for (int k = 0; k <= MAX_LEN; k++) begin
      h[k][0] = k * wi;
      h[0][k] = k * wi;
    end
    for (int yy = 1; yy <= l1; yy++)
      for (int xx = 1; xx <= l2; xx++) begin
        c = h[yy-1][xx-1] + ((a[(yy-1)*CWIDTH +: CWIDTH] == b[(xx-1)*CWIDTH +: CWIDTH]) ? wm : wmm);
        t = h[yy-1][xx] + wi;
        l = h[yy][xx-1] + wi;
        if (c >= t && c >= l) begin h[yy][xx] = c; d[yy][xx] = 2; end
        else if (t >= l)      begin h[yy][xx] = t; d[yy][xx] = 0; end
        else                  begin h[yy][xx] = l; d[yy][xx] = 1; end
      end
    exp_score = h[l1][l2];
    exp_y.delete(); exp_x.delete(); exp_d.delete(); exp_l.delete();
    y = l1; x = l2;
    while (y != 0 || x != 0) begin
      dir = (y == 0) ? 1 : (x == 0) ? 0 : d[y][x];
      ny = (dir == 1) ? y : y - 1;
      nx = (dir == 0) ? x : x - 1;
      exp_y.push_back(y); exp_x.push_back(x); exp_d.push_back(dir);
      exp_l.push_back((ny == 0 && nx == 0) ? 1 : 0);
      y = ny; x = nx;
    end
  endtask

  function automatic int path_diff();
    if (obs_y.size() != exp_y.size()) return 1000 + obs_y.size();
    for (int k = 0; k < exp_y.size(); k++)
      if (obs_y[k] != exp_y[k] || obs_x[k] != exp_x[k] || obs_d[k] != exp_d[k] || obs_l[k] != exp_l[k])
        return k;
    return -1;
  endfunction

  // Drives one job and records what comes out; bogus_at>0 pulses a different start mid-FILL.
  task automatic run_job(input int l1, input int l2, input logic [MAX_LEN*CWIDTH-1:0] a,
                         input logic [MAX_LEN*CWIDTH-1:0] b, input int wm, input int wmm,
                         input int wi, input int ready_mode, input int bogus_at);
    int cyc;
    bit prev_stall, r;
    logic [CORD_LENGTH-1:0] py, px;
    logic [1:0] pd;
    logic pl;
    obs_y.delete(); obs_x.delete(); obs_d.delete(); obs_l.delete();
    fill_cnt = 0; stable_ok = 1; timed_out = 0; prev_stall = 0;
    py = '0; px = '0; pd = '0; pl = 1'b0;
    @(negedge clk);
    len1 = CORD_LENGTH'(l1); len2 = CORD_LENGTH'(l2); s1 = a; s2 = b;
    w_match = WWIDTH'(wm); w_mismatch = WWIDTH'(wmm); w_indel = WWIDTH'(wi);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && !score_valid && fill_cnt < 400) begin
      fill_cnt++;
      if (fill_cnt == bogus_at) begin
        s1 = ~a; len1 = CORD_LENGTH'(3); start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (!score_valid) timed_out = 1;
    obs_score = int'(score);
    cyc = 0;
    while (!done && cyc < 2000) begin
      r = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
      if (prev_stall && (!out_valid || out_y !== py || out_x !== px || out_dir !== pd || out_last !== pl))
        stable_ok = 0;
      out_ready = r;
      if (out_valid && r) begin
        obs_y.push_back(int'(out_y)); obs_x.push_back(int'(out_x));
        obs_d.push_back(int'(out_dir)); obs_l.push_back(int'(out_last));
      end
      prev_stall = out_valid && !r;
      py = out_y; px = out_x; pd = out_dir; pl = out_last;
      @(negedge clk);
      cyc++;
    end
    if (!done) timed_out = 1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, score_valid, out_valid, out_last, done, err} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_flags got=%b want=000000", {busy, score_valid, out_valid, out_last, done, err});
    end
    total++;
    if (score !== '0) begin bad++; $display("[TB] FAIL reset_score got=%0d want=0", score); end
    total++;
    if ({out_y, out_x, out_dir} !== '0) begin
      bad++; $display("[TB] FAIL reset_path got y=%0d x=%0d d=%0d want 0", out_y, out_x, out_dir);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_acgt();
    int pd;
    model(4, 4, 32'hE4, 32'hE4, 1, -1, -1);
    run_job(4, 4, 32'hE4, 32'hE4, 1, -1, -1, 0, 0);
    total++;
    if (timed_out) begin bad++; $display("[TB] FAIL acgt_timeout got=1 want=0"); end
    total++;
    if (fill_cnt != 16) begin bad++; $display("[TB] FAIL acgt_fill_cycles got=%0d want=16", fill_cnt); end
    total++;
    if (obs_score != 4 || exp_score != 4) begin bad++; $display("[TB] FAIL acgt_score got=%0d want=4", obs_score); end
    pd = path_diff();
    total++;
    if (pd != -1) begin bad++; $display("[TB] FAIL acgt_path got_len=%0d want_len=%0d diff_at=%0d", obs_y.size(), exp_y.size(), pd); end
    total++;
    if (obs_y.size() != 4 || obs_d[0] != 2 || obs_l[3] != 1) begin
      bad++; $display("[TB] FAIL acgt_diag got_len=%0d want 4 corners ending in last", obs_y.size());
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL acgt_idle got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_short();
    int pd;
    model(2, 1, 32'h4, 32'h1, 1, -1, -1);
    run_job(2, 1, 32'h4, 32'h1, 1, -1, -1, 0, 0);
    total++;
    if (obs_score != 0) begin bad++; $display("[TB] FAIL short_score got=%0d want=0", obs_score); end
    pd = path_diff();
    total++;
    if (pd != -1 || timed_out) begin bad++; $display("[TB] FAIL short_path got_len=%0d want_len=%0d diff_at=%0d", obs_y.size(), exp_y.size(), pd); end
    total++;
    if (obs_y.size() != 2 || obs_d[0] != 2 || obs_d[1] != 0 || obs_y[1] != 1 || obs_x[1] != 0) begin
      bad++; $display("[TB] FAIL short_elems got_len=%0d want (2,1,CORNER),(1,0,TOP)", obs_y.size());
    end
  endtask

  task automatic test_backpressure();
    int pd;
    model(4, 4, 32'hE4, 32'hE4, 1, -1, -1);
    run_job(4, 4, 32'hE4, 32'hE4, 1, -1, -1, 1, 0);
    pd = path_diff();
    total++;
    if (pd != -1 || timed_out) begin bad++; $display("[TB] FAIL bp_path got_len=%0d want_len=%0d diff_at=%0d", obs_y.size(), exp_y.size(), pd); end
    total++;
    if (!stable_ok) begin bad++; $display("[TB] FAIL bp_hold got=changed want=stable"); end
  endtask

  task automatic test_err(input int l1, input int l2);
    int k;
    bit seen_valid, seen_done;
    seen_valid = 0; seen_done = 0;
    @(negedge clk);
    len1 = CORD_LENGTH'(l1); len2 = CORD_LENGTH'(l2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 1; k <= 4; k++) begin
      if (out_valid) seen_valid = 1;
      if (done) begin seen_done = 1; break; end
      @(negedge clk);
    end
    total++;
    if (!seen_done || k > 2) begin bad++; $display("[TB] FAIL err_done_timing got=%0d want<=2", k); end
    total++;
    if (err !== 1'b1 || score !== '0 || score_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL err_flags got err=%b score=%0d sv=%b want 1 0 0", err, score, score_valid);
    end
    total++;
    if (seen_valid) begin bad++; $display("[TB] FAIL err_no_path got=out_valid want=none"); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || err !== 1'b1) begin bad++; $display("[TB] FAIL err_hold got busy=%b err=%b want 0 1", busy, err); end
  endtask

  task automatic test_reset_mid_fill();
    int pd;
    @(negedge clk);
    len1 = 8'd8; len2 = 8'd8; s1 = 32'h1234ABCD; s2 = 32'hDEADBEEF;
    w_match = 8'd3; w_mismatch = 8'hFE; w_indel = 8'hFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({busy, score_valid, out_valid, out_last, done, err} !== 6'b0 || score !== '0) begin
      bad++; $display("[TB] FAIL midfill_reset got busy=%b sv=%b ov=%b score=%0d want all 0", busy, score_valid, out_valid, score);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model(5, 7, 32'h0000F0F0, 32'h00003C3C, 2, -1, -2);
    run_job(5, 7, 32'h0000F0F0, 32'h00003C3C, 2, -1, -2, 2, 0);
    total++;
    if (obs_score != exp_score || timed_out) begin bad++; $display("[TB] FAIL midfill_score got=%0d want=%0d", obs_score, exp_score); end
    pd = path_diff();
    total++;
    if (pd != -1) begin bad++; $display("[TB] FAIL midfill_path got_len=%0d want_len=%0d diff_at=%0d", obs_y.size(), exp_y.size(), pd); end
  endtask

  task automatic test_start_ignored();
    int pd;
    model(6, 5, 32'h00009C63, 32'h0000039C, 1, -1, -1);
    run_job(6, 5, 32'h00009C63, 32'h0000039C, 1, -1, -1, 0, 7);
    total++;
    if (fill_cnt != 30) begin bad++; $display("[TB] FAIL ignore_fill_cycles got=%0d want=30", fill_cnt); end
    total++;
    if (obs_score != exp_score) begin bad++; $display("[TB] FAIL ignore_score got=%0d want=%0d", obs_score, exp_score); end
    pd = path_diff();
    total++;
    if (pd != -1 || timed_out) begin bad++; $display("[TB] FAIL ignore_path got_len=%0d want_len=%0d diff_at=%0d", obs_y.size(), exp_y.size(), pd); end
  endtask

  task automatic test_random();
    int l1, l2, wm, wmm, wi, pd;
    logic [MAX_LEN*CWIDTH-1:0] a, b;
    for (int n = 0; n < 8; n++) begin
      l1 = $urandom_range(1, MAX_LEN); l2 = $urandom_range(1, MAX_LEN);
      a = $urandom(); b = $urandom();
      wm = $urandom_range(0, 8); wm -= 4;
      wmm = $urandom_range(0, 8); wmm -= 4;
      wi = $urandom_range(0, 8); wi -= 4;
      model(l1, l2, a, b, wm, wmm, wi);
      run_job(l1, l2, a, b, wm, wmm, wi, 2, 0);
      total++;
      if (fill_cnt != l1 * l2 || obs_score != exp_score || timed_out) begin
        bad++; $display("[TB] FAIL rand%0d_score got=%0d cyc=%0d want=%0d cyc=%0d", n, obs_score, fill_cnt, exp_score, l1 * l2);
      end
      pd = path_diff();
      total++;
      if (pd != -1 || !stable_ok) begin
        bad++; $display("[TB] FAIL rand%0d_path got_len=%0d want_len=%0d diff_at=%0d stable=%0d", n, obs_y.size(), exp_y.size(), pd, stable_ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_acgt();
    test_short();
    test_backpressure();
    test_err(0, 4);
    test_acgt();
    test_err(3, MAX_LEN + 1);
    test_reset_mid_fill();
    test_start_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nw_aligner.md
Name: nw_aligner

Overview:
- Parametrised successor to the fixed-size Needleman-Wunsch grid.
- Accepts runtime lengths (up to MAX_LEN) and runtime scoring weights.
- Fills the DP matrix one cell per cycle using a single row buffer, and stores 2-bit traceback directions in an internal memory.
- Streams the alignment path out over a valid/ready interface; sits between the sequence loader and the alignment writer/memory.

Parameters:
- MAX_LEN, 16, maximum characters per string.
- CWIDTH, 2, bits per character.
- SWIDTH, 16, signed score width; must satisfy SWIDTH >= clog2((MAX_LEN+1)*max|weight|)+2.
- CORD_LENGTH, 8, coordinate width; must satisfy 2^CORD_LENGTH > MAX_LEN.
- WWIDTH, 8, signed weight width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  job request; accepted only in IDLE.
- len1  input  CORD_LENGTH  length of s1.
- len2  input  CORD_LENGTH  length of s2.
- s1  input  MAX_LEN*CWIDTH  string 1; char y at [y*CWIDTH +: CWIDTH].
- s2  input  MAX_LEN*CWIDTH  string 2; char x at [x*CWIDTH +: CWIDTH].
- w_match  input  WWIDTH  signed match weight.
- w_mismatch  input  WWIDTH  signed mismatch weight.
- w_indel  input  WWIDTH  signed indel weight.
- busy  output  1  high in any state other than IDLE.
- score  output  SWIDTH  signed final score H[len1][len2].
- score_valid  output  1  high from end of FILL until next accepted start.
- out_valid  output  1  path element available.
- out_ready  input  1  consumer accepts element.
- out_y  output  CORD_LENGTH  DP row index i.
- out_x  output  CORD_LENGTH  DP column index j.
- out_dir  output  2  TOP=00, LEFT=01, CORNER=10.
- out_last  output  1  final path element.
- done  output  1  one-cycle pulse at job end.
- err  output  1  set when a job has illegal lengths; held until next accepted start.

Behaviour:
- Reset (async, any state, including mid-operation): state IDLE. All outputs 0: busy, score, score_valid, out_valid, out_y, out_x, out_dir, out_last, done, err. Row buffer and direction memory contents are don't-care.
- States: IDLE, FILL, TB_READ, TB_EMIT, DONE.
- IDLE
  - On start, register len1/len2/s1/s2/weights; clear score_valid and err.
  - If len1==0, len2==0, len1>MAX_LEN or len2>MAX_LEN: set err=1, score=0, go to DONE (no path emitted).
  - Otherwise go to FILL with i=1, j=1.
  - Row buffer initialised to R[j] = j*w_indel, j = 0..len2.
- FILL
  - Exactly one cell per cycle, row-major; exactly len1*len2 cycles.
  - Candidates:
    - corner = Hdiag + (s1[i-1]==s2[j-1] ? w_match : w_mismatch)
    - above = R[j] + w_indel
    - left = Hleft + w_indel
  - Boundaries: H[i][0] = i*w_indel; H[0][j] = R[j] initial value.
  - Select: CORNER if corner>=above and corner>=left; else TOP if above>=left; else LEFT. Ties favour CORNER, then TOP.
  - Write the chosen value to R[j] and the direction to dmem[i][j] in the same cycle.
  - Arithmetic: weights sign-extended to SWIDTH; two's-complement wrap, no saturation.
  - After cell (len1,len2): score=R[len2]; score_valid rises the next cycle, together with entry to TB_READ at (i,j)=(len1,len2).
- TB_READ
  - One-cycle registered read of dmem[i][j].
  - Override: i==0 forces LEFT; j==0 forces TOP.
  - Then go to TB_EMIT.
- TB_EMIT
  - Drive out_valid=1, out_y=i, out_x=j, out_dir; all held stable until out_ready.
  - out_last=1 when the move reaches (0,0).
  - On handshake, step the move (TOP: i-1; LEFT: j-1; CORNER: both).
  - If last: go to DONE. Otherwise go to TB_READ, so at most one element per 2 cycles.
  - out_valid is never withdrawn without a handshake.
- DONE: done=1 for one cycle, then IDLE. busy drops in that same IDLE cycle.
- start while busy is ignored, with no effect on the registered inputs.
- Path length equals the number of moves from (len1,len2) to (0,0), between max(len1,len2) and len1+len2.

Test Plan:
- len1=len2=4, s1=s2=ACGT (A0 C1 G2 T3), weights +1/-1/-1 -> FILL takes 16 cycles; score=4; elements (4,4,10),(3,3,10),(2,2,10),(1,1,10) with last on the 4th; done pulse follows.
- s1=AC, s2=C, len1=2, len2=1 -> score=0; elements (2,1,CORNER) then (1,0,TOP,last).
- Same ACGT job with out_ready toggling 1-of-3 cycles -> identical element sequence; out_y/out_x/out_dir/out_last never change while out_valid=1 and out_ready=0.
- len1=0 or len2=MAX_LEN+1 -> err=1, score=0, no out_valid, done pulses 2 cycles after start.
- Reset asserted mid-FILL, then a new start -> all outputs 0 during reset; the second job produces the correct score, independent of the aborted job.
- start pulsed during FILL with different s1 -> ignored; result matches the first job; score_valid stays 0 until the first job's FILL completes.
